// File: rtl/booth_multiplier_dispatcher.sv
// Issue stage for the sequential Booth multiplier: buffers tagged operand pairs,
// issues them one at a time and returns each product with its tag on a ready/valid port.
module booth_multiplier_dispatcher #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [DATA_WIDTH-1:0]       in_operand_A_i,
    input  logic [DATA_WIDTH-1:0]       in_operand_B_i,
    input  logic [TAG_WIDTH-1:0]        in_tag_i,
    output logic [DATA_WIDTH-1:0]       mul_operand_A_o,
    output logic [DATA_WIDTH-1:0]       mul_operand_B_o,
    output logic                        mul_valid_entry_o,
    input  logic                        mul_busy_i,
    input  logic                        mul_data_valid_i,
    input  logic [2*DATA_WIDTH-1:0]     mul_result_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [2*DATA_WIDTH-1:0]     out_result_o,
    output logic [TAG_WIDTH-1:0]        out_tag_o,
    output logic [$clog2(DEPTH):0]      pending_o,
    output logic                        protocol_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned RW = 2 * DATA_WIDTH;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [DATA_WIDTH-1:0]  r_mem_a   [DEPTH];
    logic [DATA_WIDTH-1:0]  r_mem_b   [DEPTH];
    logic [TAG_WIDTH-1:0]   r_mem_tag [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;

    logic [TAG_WIDTH-1:0]   r_tag_inflight;
    logic                   r_out_valid;
    logic [RW-1:0]          r_out_result;
    logic [TAG_WIDTH-1:0]   r_out_tag;
    logic                   r_err;

    logic                   w_push;
    logic                   w_issue;
    logic                   w_empty;
    logic                   w_capture;
    logic                   w_spurious;

    assign w_empty    = (r_count == CW'(0));
    assign in_ready_o = (r_count < CW'(DEPTH));
    assign w_push     = in_valid_i & in_ready_o;
    assign w_capture  = (r_state == S_WAIT) & mul_data_valid_i;
    assign w_spurious = (r_state == S_IDLE) & mul_data_valid_i;

    // Head of queue is always visible to the multiplier; zero when nothing is queued.
    assign mul_operand_A_o   = w_empty ? DATA_WIDTH'(0) : r_mem_a[r_rd_ptr];
    assign mul_operand_B_o   = w_empty ? DATA_WIDTH'(0) : r_mem_b[r_rd_ptr];
    assign mul_valid_entry_o = w_issue;

    assign out_valid_o    = r_out_valid;
    assign out_result_o   = r_out_result;
    assign out_tag_o      = r_out_tag;
    assign pending_o      = r_count;
    assign protocol_err_o = r_err;

    // FIFO storage (contents are only observed through the occupancy-gated head)
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]   <= in_operand_A_i;
            r_mem_b[r_wr_ptr]   <= in_operand_B_i;
            r_mem_tag[r_wr_ptr] <= in_tag_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue only when the output slot will be free by the time the result returns
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty && !mul_busy_i && (!r_out_valid || out_ready_i)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mul_data_valid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tag_inflight <= TAG_WIDTH'(0);
        end else if (w_issue) begin
            r_tag_inflight <= r_mem_tag[r_rd_ptr];
        end
    end

    // Output slot: a capture wins over a same-cycle handshake
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_out_valid  <= 1'b0;
            r_out_result <= RW'(0);
            r_out_tag    <= TAG_WIDTH'(0);
        end else if (w_capture) begin
            r_out_valid  <= 1'b1;
            r_out_result <= mul_result_i;
            r_out_tag    <= r_tag_inflight;
        end else if (out_ready_i) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err <= 1'b0;
        end else if (w_spurious) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: doc/booth_multiplier_dispatcher.md
# booth_multiplier_dispatcher

Upstream issue stage for the sequential Booth multiplier. Buffers signed operand pairs with a tag in a small FIFO and issues them one at a time using the multiplier's single-cycle `valid_entry` pulse. It captures the one-cycle `data_valid` result and presents it with its tag on a ready/valid output port. Only one operation is ever in flight; the output slot is guaranteed free before each issue, so no result is lost.

## Interface
- `DATA_WIDTH`, 32, operand width; must match the multiplier.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `TAG_WIDTH`, 4, width of the user tag carried with each operation.

Ports:
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `in_valid_i` in 1: input operation valid.
- `in_ready_o` out 1: FIFO can accept an operation.
- `in_operand_A_i` in DATA_WIDTH: multiplier, signed.
- `in_operand_B_i` in DATA_WIDTH: multiplicand, signed.
- `in_tag_i` in TAG_WIDTH: tag.
- `mul_operand_A_o`, `mul_operand_B_o` out DATA_WIDTH: drive the multiplier operands.
- `mul_valid_entry_o` out 1: issue pulse.
- `mul_busy_i` in 1: multiplier busy.
- `mul_data_valid_i` in 1: multiplier result valid (one cycle).
- `mul_result_i` in 2*DATA_WIDTH: multiplier product.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts.
- `out_result_o` out 2*DATA_WIDTH: signed product.
- `out_tag_o` out TAG_WIDTH: tag of that product.
- `pending_o` out $clog2(DEPTH)+1: FIFO occupancy.
- `protocol_err_o` out 1: sticky error.

## Operation
- **FIFO**
  - Push when `in_valid_i & in_ready_o`.
  - `in_ready_o = (pending_o < DEPTH)`. It does not depend on a same-cycle pop.
  - Storage is registered. Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave `pending_o` unchanged.
- **State machine**
  - IDLE: no operation in flight.
    - Issue condition: FIFO not empty, `!mul_busy_i`, and output slot free (`!out_valid_o | out_ready_i`).
    - On issue, the cycle is the issue cycle:
      - `mul_valid_entry_o = 1` for exactly that cycle.
      - `mul_operand_A_o` and `mul_operand_B_o` show the FIFO head combinationally.
      - The head is popped.
      - The head tag is latched into the in-flight tag register.
      - Next state is WAIT.
  - WAIT: waiting for the result.
    - `mul_valid_entry_o = 0`.
    - On `mul_data_valid_i`: load `mul_result_i` and the in-flight tag into the output register, set `out_valid_o`, go to IDLE.
    - In the first IDLE cycle after a result, a new issue is allowed; issue is therefore back-to-back.
- **Operand outputs**: when not issuing, `mul_operand_*_o` still show the FIFO head, or 0 when the FIFO is empty.
- **Output register**
  - Holds its value while `out_valid_o & !out_ready_i`.
  - Clears `out_valid_o` on handshake unless it is reloaded in the same cycle.
  - Results leave in FIFO (issue) order.
- **Errors**: `mul_data_valid_i` asserted while in IDLE:
  - The result is ignored: no output load.
  - `protocol_err_o` is set and holds until reset.
- **No arithmetic**: the block passes `mul_result_i` through unmodified. All values are two's complement.

## Timing
- **Reset values**: all outputs 0 except `in_ready_o = 1`. FIFO empty, state IDLE, error cleared.
- **Reset mid-operation**: the in-flight operation and FIFO contents are discarded. The multiplier must be reset by the same `rst_n_i`.
- **Push to issue**: a push at edge N gives the earliest issue in cycle N+1.
- **Latency**: with multiplier latency L = DATA_WIDTH/log2(RADIX)+1 counted from the issue cycle, `out_valid_o` rises the cycle after `mul_data_valid_i`.
  - Example: DATA_WIDTH = 32, RADIX = 16, so L = 9.
  - The end-to-end latency from push to `out_valid_o` is L+2 cycles.
- **Backpressure**: `out_ready_i` held low blocks further issue after the current result is captured. The FIFO keeps accepting until full.
- **Throughput**: one result per L+1 cycles with continuous input and `out_ready_i = 1`.

## Test plan
- **Single signed product**: push A=7, B=-3 (0xFFFFFFFD), tag=5 with `out_ready_i = 1`.
  - Required: `mul_valid_entry_o` is high for exactly one cycle.
  - Required: `out_result_o = 64'hFFFF_FFFF_FFFF_FFEB` and `out_tag_o = 5`, at L+2 cycles after the push.
- **Fill FIFO**: push 5 operations back-to-back with the multiplier stalled. Operations: (1,2,t0), (−1,−1,t1), (3,−4,t2), (0,9,t3), (5,5,t4).
  - Required: `in_ready_o` drops after the 4th acceptance. Operation 5 is retried.
  - Required: outputs are 2, 1, −12, 0, 25 with tags t0..t4, in order.
- **Output backpressure**: 3 operations queued, `out_ready_i = 0`.
  - Required: the first result is held stable and no second issue occurs.
  - Required: after `out_ready_i = 1` for one cycle, the next issue happens in that same cycle.
- **Extremes**: A=B=0x80000000 gives 64'h4000_0000_0000_0000. A=0x7FFFFFFF, B=0x80000000 gives 64'hC000_0000_8000_0000.
- **Reset mid-flight**: assert `rst_n_i` low during WAIT with 2 operations queued.
  - Required: all outputs return to reset values immediately, `pending_o = 0`, and no stale `out_valid_o` after release.
- **Spurious result**: pulse `mul_data_valid_i` while in IDLE with an empty FIFO.
  - Required: `protocol_err_o = 1` and stays set; `out_valid_o` stays 0.
